// File: rtl/rv_core_pkg.sv
// Shared constants and datapath types for the RV32 single-cycle core.
package rv_core_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

    // Index of the hardwired-zero register.
    localparam reg_idx_t X0_IDX = '0;

endpackage

// File: rtl/riscv_reg_file.sv
// Integer register file: 32 x XLEN, two combinational read ports, one
// synchronous write port. x0 is not stored and always reads as zero.
module riscv_reg_file #(
    parameter int XLEN     = rv_core_pkg::XLEN,
    parameter int NUM_REGS = rv_core_pkg::NUM_REGS,
    parameter int ADDR_W   = rv_core_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] read_reg_num1,
    input  logic [ADDR_W-1:0] read_reg_num2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [XLEN-1:0]   write_data,
    output logic [XLEN-1:0]   read_data1,
    output logic [XLEN-1:0]   read_data2,
    input  logic              regwrite,
    input  logic              clock,
    input  logic              reset
);

    // Storage for x1..x(NUM_REGS-1); x0 has no flops behind it.
    logic [XLEN-1:0]     r_regs [1:NUM_REGS-1];

    // One-hot write enable per stored register.
    logic [NUM_REGS-1:1] w_wr_en;

    logic                w_rd1_is_x0;
    logic                w_rd2_is_x0;

    // Decode rd into a per-entry enable; index 0 has no entry, so writes to x0
    // simply never match anything.
    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_wr_dec
            assign w_wr_en[gi] = regwrite && (write_reg == ADDR_W'(gi));
        end
    endgenerate

    // Asynchronous clear of every register, otherwise load the enabled entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_wr_en[i]) begin
                    r_regs[i] <= write_data;
                end
            end
        end
    end

    // Zero-latency reads with no write bypass; x0 reads as constant zero.
    assign w_rd1_is_x0 = (read_reg_num1 == '0);
    assign w_rd2_is_x0 = (read_reg_num2 == '0);
    assign read_data1  = w_rd1_is_x0 ? '0 : r_regs[read_reg_num1];
    assign read_data2  = w_rd2_is_x0 ? '0 : r_regs[read_reg_num2];

endmodule

// File: tb/tb_riscv_reg_file.sv
// Self-checking bench for riscv_reg_file: directed scenarios followed by
// randomized traffic compared every cycle against an array model.
module tb_riscv_reg_file;

    logic [4:0]  ra1, ra2, wa;
    logic [31:0] wd, rd1, rd2;
    logic        we, clk, rst;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    // Behavioural model: 32 architectural registers, x0 kept at zero.
    logic [31:0] model [0:31];

    riscv_reg_file dut (
        .read_reg_num1 (ra1),
        .read_reg_num2 (ra2),
        .write_reg     (wa),
        .write_data    (wd),
        .read_data1    (rd1),
        .read_data2    (rd2),
        .regwrite      (we),
        .clock         (clk),
        .reset         (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    // Inputs change 2ns after a rising edge, so they are stable at both edges.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Model update: an enabled, non-reset edge stores to any index except 0.
    always @(posedge clk) begin
        if (!rst && we && (wa != 5'd0)) model[wa] = wd;
    end

    // Compare process: both read ports against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_rd1", rd1, model[ra1]);
            check("model_rd2", rd2, model[ra2]);
            $display("cycle t=%0t rst=%0b we=%0b wa=%0d wd=%08h ra1=%0d rd1=%08h ra2=%0d rd2=%08h",
                     $time, rst, we, wa, wd, ra1, rd1, ra2, rd2);
        end
    end

    initial begin
        clear_model();
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = 5'd0; ra2 = 5'd1;

        // 1: reset holds everything at zero; release on a clock edge.
        #3;
        check("reset_x0", rd1, 32'd0);
        check("reset_x1", rd2, 32'd0);
        @(posedge clk);
        @(posedge clk);
        rst = 1'b0;
        #2;
        cmp_en = 1;

        // 2: a write to x0 is ignored.
        we = 1'b1; wa = 5'd0; wd = 32'd20; ra1 = 5'd0; ra2 = 5'd0;
        next_cycle();
        check("x0_rd1", rd1, 32'd0);
        check("x0_rd2", rd2, 32'd0);

        // 3: no bypass before the edge, new value right after it.
        we = 1'b1; wa = 5'd1; wd = 32'd30; ra1 = 5'd0; ra2 = 5'd1;
        #1;
        check("pre_edge_x1", rd2, 32'd0);
        next_cycle();
        check("post_edge_x1", rd2, 32'd30);
        check("post_edge_x0", rd1, 32'd0);

        // 4: repeated write keeps the value; x2 untouched.
        next_cycle();
        check("repeat_x1", rd2, 32'd30);
        we = 1'b0; ra1 = 5'd1; ra2 = 5'd2;
        #1;
        check("x1_port1", rd1, 32'd30);
        check("x2_port2", rd2, 32'd0);

        // 5: disabled write to x31 has no effect, enabled one lands.
        we = 1'b0; wa = 5'd31; wd = 32'hDEADBEEF; ra1 = 5'd31; ra2 = 5'd31;
        next_cycle();
        check("x31_disabled", rd1, 32'd0);
        we = 1'b1;
        next_cycle();
        check("x31_rd1", rd1, 32'hDEADBEEF);
        check("x31_rd2", rd2, 32'hDEADBEEF);

        // 6: reset asserted mid-cycle clears immediately and stays cleared.
        we = 1'b0; ra1 = 5'd1; ra2 = 5'd31;
        #1;
        check("pre_rst_x1", rd1, 32'd30);
        rst = 1'b1;
        clear_model();
        #1;
        check("async_rst_x1", rd1, 32'd0);
        check("async_rst_x31", rd2, 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        check("after_rst_x1", rd1, 32'd0);

        // Randomized traffic with occasional mid-cycle resets.
        for (int c = 0; c < 400; c++) begin
            we  = 1'($urandom_range(0, 3) != 0);
            wa  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = 5'($urandom_range(0, 31));
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 63) == 0) begin
                rst = 1'b1;
                clear_model();
            end
            next_cycle();
        end

        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
